// File: rtl/wb_cmd_master_if.sv
// Command/response handshake and Wishbone B4 classic bus bundle for wb_cmd_master.
// The master modport is the command master's view; slave is the view of whoever surrounds it.
interface wb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_adr;
    logic [DATA_W-1:0] cmd_dat;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic [1:0]        rsp_status;

    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: turns one command into a bus cycle with
// retry backoff and optional timeout, then holds the response until it is consumed.
module wb_cmd_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    wb_cmd_master_if.master bus
);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [1:0] STATUS_OK  = 2'b00;
    localparam logic [1:0] STATUS_ERR = 2'b01;
    localparam logic [1:0] STATUS_RTY = 2'b10;
    localparam logic [1:0] STATUS_TMO = 2'b11;

    typedef enum logic [1:0] {StIdle, StBus, StBackoff, StResp} state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [RTY_W-1:0]  rty_cnt_q, rty_cnt_d;
    logic [TMO_W-1:0]  tmo_inc;

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        tmo_cnt_d    = tmo_cnt_q;
        rty_cnt_d    = rty_cnt_q;
        tmo_inc      = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d   = StBus;
                    adr_d     = bus.cmd_adr;
                    dat_d     = bus.cmd_dat;
                    we_d      = bus.cmd_we;
                    tmo_cnt_d = '0;
                    rty_cnt_d = '0;
                end
            end
            StBus: begin
                // Terminations take priority over a timeout landing in the same cycle.
                if (bus.wb_ack_i) begin
                    state_d      = StResp;
                    rsp_dat_d    = we_q ? '0 : bus.wb_dat_i;
                    rsp_status_d = STATUS_OK;
                end else if (bus.wb_err_i) begin
                    state_d      = StResp;
                    rsp_dat_d    = '0;
                    rsp_status_d = STATUS_ERR;
                end else if (bus.wb_rty_i) begin
                    if (rty_cnt_q < RTY_MAX) begin
                        state_d   = StBackoff;
                        rty_cnt_d = rty_cnt_q + 1'b1;
                    end else begin
                        state_d      = StResp;
                        rsp_dat_d    = '0;
                        rsp_status_d = STATUS_RTY;
                    end
                end else if (TIMEOUT > 0) begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        state_d      = StResp;
                        rsp_dat_d    = '0;
                        rsp_status_d = STATUS_TMO;
                    end
                end
            end
            StBackoff: begin
                state_d   = StBus;
                tmo_cnt_d = '0;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake/bus strobes are registered copies of the next state.
        cmd_ready_d = (state_d == StIdle);
        cyc_d       = (state_d == StBus);
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= StIdle;
            cmd_ready_q  <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= STATUS_OK;
            tmo_cnt_q    <= '0;
            rty_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rty_cnt_q    <= rty_cnt_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dat    = rsp_dat_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.wb_we_o    = we_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
    assign bus.wb_cti_o   = 3'b000;
    assign bus.wb_bte_o   = 2'b00;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a registered Wishbone slave model with selectable termination,
// and a queue of expected responses pushed per command and popped when a response is taken.
module tb_wb_cmd_master;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 3;

    localparam int M_ACK    = 0;
    localparam int M_RTY    = 1;
    localparam int M_NONE   = 2;
    localparam int M_ERR    = 3;
    localparam int M_ACKERR = 4;

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  st;
    } exp_t;

    logic wb_clk = 1'b0;
    logic wb_rst_n = 1'b0;

    wb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_cmd_master #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .wb_clk  (wb_clk),
        .wb_rst_n(wb_rst_n),
        .bus     (bus)
    );

    always #5 wb_clk = ~wb_clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    bit          stb_trace[$];

    // Slave: presents its termination on the slv_lat-th strobe cycle (slv_lat >= 2).
    int          slv_mode = M_ACK;
    int          slv_lat = 2;
    logic [31:0] slv_rdata = 32'h0;
    int          slv_cnt = 0;
    logic        slv_ack = 1'b0;
    logic        slv_err = 1'b0;
    logic        slv_rty = 1'b0;

    assign bus.wb_ack_i = slv_ack;
    assign bus.wb_err_i = slv_err;
    assign bus.wb_rty_i = slv_rty;
    assign bus.wb_dat_i = slv_rdata;

    always @(posedge wb_clk) begin
        if (bus.wb_cyc_o && bus.wb_stb_o && !(slv_ack || slv_err || slv_rty)) begin
            slv_cnt <= slv_cnt + 1;
            if (slv_cnt + 1 == slv_lat - 1 && slv_mode != M_NONE) begin
                slv_ack <= (slv_mode == M_ACK) || (slv_mode == M_ACKERR);
                slv_err <= (slv_mode == M_ERR) || (slv_mode == M_ACKERR);
                slv_rty <= (slv_mode == M_RTY);
            end
        end else begin
            slv_cnt <= 0;
            slv_ack <= 1'b0;
            slv_err <= 1'b0;
            slv_rty <= 1'b0;
        end
    end

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output bit ok);
        ok = 1'b0;
        @(negedge wb_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge wb_clk);
        end
        if (ok) @(posedge wb_clk);
        @(negedge wb_clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Called on the negedge of the first cycle after the handshake (cycle N+1).
    task automatic wait_rsp(output int lat, output int stb_n, output bit got);
        stb_trace.delete();
        lat   = 0;
        stb_n = 0;
        got   = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (bus.rsp_valid) begin
                lat = i;
                got = 1'b1;
                break;
            end
            stb_trace.push_back(bus.wb_stb_o);
            if (bus.wb_stb_o) stb_n++;
            @(negedge wb_clk);
        end
    endtask

    task automatic take_rsp(output logic [31:0] dat, output logic [1:0] st);
        dat = bus.rsp_dat;
        st  = bus.rsp_status;
        bus.rsp_ready = 1'b1;
        @(negedge wb_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.cmd_ready, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.rsp_valid} !== 5'b0 ||
            bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0 || bus.rsp_dat !== 32'h0 ||
            bus.rsp_status !== 2'b00 || bus.wb_cti_o !== 3'b000 || bus.wb_bte_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: rdy=%b cyc=%b stb=%b we=%b rv=%b adr=%h dat=%h st=%b, want all 0",
                     bus.cmd_ready, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.rsp_valid,
                     bus.wb_adr_o, bus.wb_dat_o, bus.rsp_status);
        end
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", bus.cmd_ready);
        end
        @(negedge wb_clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_read();
        bit ok, got;
        int lat, stb_n;
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = M_ACK; slv_lat = 2; slv_rdata = 32'h0000_00A5;
        exp_q.push_back('{dat: 32'h0000_00A5, st: 2'b00});
        send_cmd(1'b0, 32'h0, 32'h0, ok);
        wait_rsp(lat, stb_n, got);
        checks++;
        if (!ok || !got || lat != 3 || stb_n != 2) begin
            errors++;
            $display("FAIL read_timing: ok=%0d got=%0d lat=%0d stb=%0d, want lat=3 stb=2",
                     ok, got, lat, stb_n);
        end
        take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL read_rsp: got %h/%b want %h/%b", d, s, e.dat, e.st);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_rsp: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write();
        bit ok, got;
        int stb_n, bad;
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = M_ACK; slv_lat = 4; slv_rdata = 32'hDEAD_BEEF;
        exp_q.push_back('{dat: 32'h0, st: 2'b00});
        send_cmd(1'b1, 32'h4, 32'hFF, ok);
        stb_n = 0; bad = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.wb_stb_o) begin
                stb_n++;
                if (bus.wb_we_o !== 1'b1 || bus.wb_dat_o !== 32'hFF || bus.wb_adr_o !== 32'h4)
                    bad++;
            end
            @(negedge wb_clk);
        end
        checks++;
        if (!ok || !got || bad != 0 || stb_n != 4) begin
            errors++;
            $display("FAIL write_bus: ok=%0d got=%0d unstable=%0d stb=%0d, want stable for 4",
                     ok, got, bad, stb_n);
        end
        take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL write_rsp: got %h/%b want %h/%b", d, s, e.dat, e.st);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        int lat, stb_n;
        logic [31:0] d, wd;
        logic [1:0] s;
        logic we;
        exp_t e;
        slv_mode = M_ACK;
        for (int k = 0; k < 4; k++) begin
            we        = k[0];
            wd        = $urandom;
            slv_rdata = $urandom;
            slv_lat   = 2 + (k % 3);
            exp_q.push_back('{dat: we ? 32'h0 : slv_rdata, st: 2'b00});
            send_cmd(we, 32'h100 + 32'(k * 4), wd, ok);
            wait_rsp(lat, stb_n, got);
            checks++;
            if (!ok || !got || stb_n != slv_lat) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: ok=%0d got=%0d stb=%0d want %0d",
                         k, ok, got, stb_n, slv_lat);
            end
            take_rsp(d, s);
            e = exp_q.pop_front();
            checks++;
            if (d !== e.dat || s !== e.st) begin
                errors++;
                $display("FAIL b2b_rsp[%0d]: got %h/%b want %h/%b", k, d, s, e.dat, e.st);
            end
        end
    endtask

    task automatic test_term(input int mode, input string name);
        bit ok, got;
        int lat, stb_n;
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = mode; slv_lat = 2; slv_rdata = 32'h0000_1234;
        exp_q.push_back('{dat: (mode == M_ERR) ? 32'h0 : 32'h0000_1234,
                          st: (mode == M_ERR) ? 2'b01 : 2'b00});
        send_cmd(1'b0, 32'h20, 32'h0, ok);
        wait_rsp(lat, stb_n, got);
        d = 32'hX; s = 2'bXX;
        if (got) take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (!ok || !got || d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL %s: ok=%0d got=%0d rsp %h/%b want %h/%b",
                     name, ok, got, d, s, e.dat, e.st);
        end
    endtask

    task automatic test_retry();
        bit ok, got;
        int lat, stb_n, bad, rises;
        bit exp_tr[$];
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = M_RTY; slv_lat = 2;
        exp_q.push_back('{dat: 32'h0, st: 2'b10});
        send_cmd(1'b0, 32'h8, 32'h0, ok);
        wait_rsp(lat, stb_n, got);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            exp_tr.push_back(1'b1);
            exp_tr.push_back(1'b1);
            if (a < MAX_RETRY) exp_tr.push_back(1'b0);
        end
        bad = (stb_trace.size() != exp_tr.size()) ? 1 : 0;
        rises = 0;
        for (int i = 0; i < stb_trace.size(); i++) begin
            if (i < exp_tr.size() && stb_trace[i] != exp_tr[i]) bad++;
            if (stb_trace[i] && (i == 0 || !stb_trace[i-1])) rises++;
        end
        checks++;
        if (!ok || !got || bad != 0 || rises != MAX_RETRY + 1) begin
            errors++;
            $display("FAIL retry_attempts: ok=%0d got=%0d attempts=%0d trace_len=%0d, want %0d/%0d",
                     ok, got, rises, stb_trace.size(), MAX_RETRY + 1, exp_tr.size());
        end
        d = 32'hX; s = 2'bXX;
        if (got) take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL retry_rsp: got %h/%b want %h/%b", d, s, e.dat, e.st);
        end
    endtask

    task automatic test_timeout();
        bit ok, got;
        int lat, stb_n;
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = M_NONE; slv_rdata = 32'h5555_5555;
        exp_q.push_back('{dat: 32'h0, st: 2'b11});
        send_cmd(1'b0, 32'hC, 32'h0, ok);
        wait_rsp(lat, stb_n, got);
        checks++;
        if (!ok || !got || stb_n != TIMEOUT || lat != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len: ok=%0d got=%0d stb=%0d lat=%0d, want stb=%0d lat=%0d",
                     ok, got, stb_n, lat, TIMEOUT, TIMEOUT + 1);
        end
        d = 32'hX; s = 2'bXX;
        if (got) take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL timeout_rsp: got %h/%b want %h/%b", d, s, e.dat, e.st);
        end
    endtask

    task automatic test_hold();
        bit ok, got;
        int lat, stb_n, bad;
        logic [31:0] d;
        logic [1:0] s;
        exp_t e;
        slv_mode = M_ACK; slv_lat = 2; slv_rdata = 32'h5A5A_0F0F;
        exp_q.push_back('{dat: 32'h5A5A_0F0F, st: 2'b00});
        send_cmd(1'b0, 32'h40, 32'h0, ok);
        wait_rsp(lat, stb_n, got);
        bus.cmd_valid = 1'b1;
        bus.cmd_adr   = 32'h80;
        bad = got ? 0 : 1;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== exp_q[0].dat ||
                bus.rsp_status !== exp_q[0].st || bus.cmd_ready !== 1'b0 ||
                bus.wb_stb_o !== 1'b0)
                bad++;
            @(negedge wb_clk);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL hold_stable: ok=%0d violations=%0d want 0", ok, bad);
        end
        take_rsp(d, s);
        e = exp_q.pop_front();
        checks++;
        if (d !== e.dat || s !== e.st) begin
            errors++;
            $display("FAIL hold_rsp: got %h/%b want %h/%b", d, s, e.dat, e.st);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        slv_mode = M_NONE;
        send_cmd(1'b1, 32'h60, 32'h1234_5678, ok);
        @(negedge wb_clk);
        checks++;
        if (!ok || bus.wb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_bus_active: ok=%0d stb=%b want stb=1", ok, bus.wb_stb_o);
        end
        #2 wb_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.wb_adr_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: cyc=%b stb=%b adr=%h want 0/0/0",
                     bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o);
        end
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge wb_clk);
            if (bus.rsp_valid !== 1'b0 || bus.wb_stb_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_discard: stray rsp/stb cycles=%0d want 0", bad);
        end
        test_read();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_term(M_ERR, "err_rsp");
        test_term(M_ACKERR, "ack_err_priority");
        test_retry();
        test_timeout();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, Wishbone address width; DATA_W, 32, data width (1..32); TIMEOUT, 255, max bus cycles awaiting termination (0 = disabled); MAX_RETRY, 3, reissues allowed after wb_rty_i.
REQ-002 SHALL have ports (name direction width meaning):
 wb_clk  in  1  sole clock, all state on rising edge
 wb_rst_n  in  1  reset, asynchronous, active-low
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when both high
 cmd_we  in  1  1 = write, 0 = read
 cmd_adr  in  ADDR_W  target address
 cmd_dat  in  DATA_W  write data
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when both high
 rsp_dat  out  DATA_W  read data (0 for writes and failures)
 rsp_status  out  2  00 ok, 01 err, 10 retries exhausted, 11 timeout
 wb_adr_o  out  ADDR_W; wb_dat_o  out  DATA_W; wb_we_o  out  1; wb_cyc_o  out  1; wb_stb_o  out  1
 wb_cti_o  out  3  constant 000 (classic); wb_bte_o  out  2  constant 00
 wb_dat_i  in  DATA_W; wb_ack_i  in  1; wb_err_i  in  1; wb_rty_i  in  1

Function
REQ-003 SHALL implement states IDLE, BUS, BACKOFF, RESP; one transaction outstanding at a time.
REQ-004 SHALL assert cmd_ready only in IDLE (registered); handshake latches cmd_we/adr/dat into wb_we_o/wb_adr_o/wb_dat_o, clears timeout and retry counters, enters BUS.
REQ-005 SHALL drive wb_cyc_o = wb_stb_o = 1 from the first cycle in BUS (cycle after handshake) until the cycle after termination is sampled; all Wishbone outputs registered.
REQ-006 SHALL hold wb_adr_o, wb_dat_o, wb_we_o stable while wb_cyc_o is high.
REQ-007 SHALL sample terminations only in BUS with priority ack > err > rty; terminations outside BUS ignored.
REQ-008 On ack: capture wb_dat_i into rsp_dat if read (0 if write), status 00, go RESP, deassert cyc/stb next cycle.
REQ-009 On err: rsp_dat 0, status 01, go RESP.
REQ-010 On rty with retry_cnt < MAX_RETRY: increment retry_cnt, go BACKOFF (cyc/stb low exactly one cycle), return to BUS re-driving the same command, timeout counter cleared.
REQ-011 On rty with retry_cnt == MAX_RETRY: rsp_dat 0, status 10, go RESP.
REQ-012 With TIMEOUT > 0: count BUS cycles without termination; when count reaches TIMEOUT, drop cyc/stb, rsp_dat 0, status 11, go RESP; termination arriving in the same cycle as timeout wins over timeout.
REQ-013 SHALL hold rsp_valid high with rsp_dat/rsp_status stable in RESP until rsp_ready; then IDLE next cycle (cmd_ready high).
REQ-014 Minimum command-to-response latency with a zero-wait slave: handshake cycle N, stb at N+1, ack sampled N+2, rsp_valid at N+3.
REQ-015 Counters SHALL saturate, never wrap; widths sized by clog2(TIMEOUT+1) and clog2(MAX_RETRY+1).

Reset
REQ-016 wb_rst_n low SHALL immediately force IDLE, cyc/stb/we/rsp_valid 0, cmd_ready 0 during reset, wb_adr_o/wb_dat_o/rsp_dat 0, rsp_status 00, counters 0; in-flight command discarded with no response.
REQ-017 cmd_ready SHALL rise on the first clock edge after wb_rst_n deasserts.

Verification
REQ-018 Read, zero-wait slave returning 0x0000_00A5 at adr 0x0: cmd_valid at N -> stb N+1..N+2, rsp_valid N+3, rsp_dat 0xA5, status 00.
REQ-019 Write 0xFF to adr 0x4, slave acks after 3 wait cycles -> wb_dat_o 0xFF, wb_we_o 1 stable for 4 stb cycles, rsp_dat 0, status 00.
REQ-020 Slave asserts rty on every attempt, MAX_RETRY=3 -> 4 bus attempts each separated by 1 idle cycle, then status 10.
REQ-021 TIMEOUT=8, slave never terminates -> stb high exactly 8 cycles, status 11; ack+err together -> status 00.
REQ-022 rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready stays 0, no new stb.
REQ-023 wb_rst_n pulsed low mid-BUS -> cyc/stb drop asynchronously, no rsp_valid, next command completes normally.
